// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI frame slave.
//   SPI_MODE0..3 : {CPOL,CPHA} encodings
//   MSGID_W      : width of the frame header compared against MSGID
//   clog2        : ceil(log2(value)), used to size the bit counter
//   frm_state_t  : frame FSM states
package spi_slave_pkg;

   localparam logic [1:0] SPI_MODE0 = 2'd0;
   localparam logic [1:0] SPI_MODE1 = 2'd1;
   localparam logic [1:0] SPI_MODE2 = 2'd2;
   localparam logic [1:0] SPI_MODE3 = 2'd3;

   localparam int unsigned MSGID_W = 32;

   typedef enum logic {
      FRM_IDLE,
      FRM_ACTIVE
   } frm_state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned pow = 1; pow < value; pow = pow << 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/spi_slave_frame_sync.sv
// 2-FF synchroniser for one asynchronous SPI pin, followed by a registered
// edge detector.
//   clk, rst_n : system clock, asynchronous active-low reset
//   async_i    : raw pin
//   sync_o     : synchronised level
//   rise_o     : 1-cycle pulse on a synchronised rising edge
//   fall_o     : 1-cycle pulse on a synchronised falling edge
module spi_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   // [0],[1] synchroniser stages; [2] previous synchronised level
   logic [2:0] pipe_q, pipe_d;

   always_comb begin
      pipe_d = {pipe_q[1:0], async_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign sync_o = pipe_q[1];
   assign rise_o = pipe_q[1] & ~pipe_q[2];
   assign fall_o = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/spi_slave_frame.sv
// SPI slave exchanging one fixed-length frame per SSEL-low window.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   SPI_SCK     : serial clock (asynchronous)
//   SPI_SSEL    : chip select, active low (asynchronous)
//   SPI_MOSI    : host -> slave data
//   SPI_MISO    : slave -> host data, MSB first, 0 while deselected
//   tx_data     : frame to transmit, captured at SSEL fall
//   rx_data     : last accepted frame
//   rx_valid    : 1-cycle pulse when rx_data updates
//   frame_err   : 1-cycle pulse when a frame is rejected
//   pkg_timeout : 1 while no frame was accepted within TIMEOUT cycles
module spi_slave_frame
   import spi_slave_pkg::*;
#(
   parameter int unsigned BUFFER_SIZE = 96,
   parameter logic [31:0] MSGID       = 32'h74697277,
   parameter int unsigned SPI_MODE    = 0,
   parameter logic [31:0] TIMEOUT     = 32'd5000000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   SPI_SCK,
   input  logic                   SPI_SSEL,
   input  logic                   SPI_MOSI,
   output logic                   SPI_MISO,
   input  logic [BUFFER_SIZE-1:0] tx_data,
   output logic [BUFFER_SIZE-1:0] rx_data,
   output logic                   rx_valid,
   output logic                   frame_err,
   output logic                   pkg_timeout
);

   localparam logic [1:0]       MODE     = 2'(SPI_MODE);
   localparam bit               CPOL     = (MODE == SPI_MODE2) || (MODE == SPI_MODE3);
   localparam bit               CPHA     = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);
   localparam int unsigned      CNT_W    = clog2(BUFFER_SIZE + 2);
   localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(BUFFER_SIZE);
   localparam logic [CNT_W-1:0] BIT_SAT  = CNT_W'(BUFFER_SIZE + 1);

   logic sck_rise, sck_fall, sck_level_unused;
   logic ssel_rise, ssel_fall, ssel_level_unused;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   spi_sync u_sync_sck (
      .clk    (clk),
      .rst_n  (rst_n),
      .async_i(SPI_SCK),
      .sync_o (sck_level_unused),
      .rise_o (sck_rise),
      .fall_o (sck_fall)
   );

   spi_sync u_sync_ssel (
      .clk    (clk),
      .rst_n  (rst_n),
      .async_i(SPI_SSEL),
      .sync_o (ssel_level_unused),
      .rise_o (ssel_rise),
      .fall_o (ssel_fall)
   );

   spi_sync u_sync_mosi (
      .clk    (clk),
      .rst_n  (rst_n),
      .async_i(SPI_MOSI),
      .sync_o (mosi_s),
      .rise_o (mosi_rise_unused),
      .fall_o (mosi_fall_unused)
   );

   frm_state_t             state_q, state_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [BUFFER_SIZE-1:0] rx_shift_q, rx_shift_d;
   logic [BUFFER_SIZE-1:0] tx_shift_q, tx_shift_d;
   logic [BUFFER_SIZE-1:0] rx_data_q, rx_data_d;
   logic                   miso_q, miso_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic [31:0]            tmo_cnt_q, tmo_cnt_d;
   logic                   pkg_timeout_q, pkg_timeout_d;

   logic lead_edge, trail_edge, sample_edge, shift_edge;

   always_comb begin
      lead_edge   = CPOL ? sck_fall : sck_rise;
      trail_edge  = CPOL ? sck_rise : sck_fall;
      sample_edge = CPHA ? trail_edge : lead_edge;
      shift_edge  = CPHA ? lead_edge : trail_edge;

      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      tx_shift_d    = tx_shift_q;
      rx_data_d     = rx_data_q;
      miso_d        = miso_q;
      rx_valid_d    = 1'b0;
      frame_err_d   = 1'b0;
      tmo_cnt_d     = (tmo_cnt_q >= TIMEOUT) ? tmo_cnt_q : tmo_cnt_q + 32'd1;
      pkg_timeout_d = (tmo_cnt_q >= TIMEOUT);

      unique case (state_q)
         FRM_IDLE: begin
            // Entered only on an observed SSEL fall, so a reset released
            // mid-frame waits for the next fall.
            miso_d = 1'b0;
            if (ssel_fall) begin
               state_d    = FRM_ACTIVE;
               bit_cnt_d  = '0;
               rx_shift_d = '0;
               // MSB goes out at SSEL fall in every mode; tx_shift then holds
               // the remaining bits MSB-aligned. This is why the CPHA=1
               // leading edge at bit count 0 must not shift again.
               miso_d     = tx_data[BUFFER_SIZE-1];
               tx_shift_d = tx_data << 1;
            end
         end
         FRM_ACTIVE: begin
            if (ssel_rise) begin
               state_d = FRM_IDLE;
               miso_d  = 1'b0;
               if (bit_cnt_q == BIT_FULL &&
                   rx_shift_q[BUFFER_SIZE-1 -: MSGID_W] == MSGID) begin
                  rx_data_d  = rx_shift_q;
                  rx_valid_d = 1'b1;
                  tmo_cnt_d  = '0;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               if (sample_edge) begin
                  rx_shift_d = {rx_shift_q[BUFFER_SIZE-2:0], mosi_s};
                  if (bit_cnt_q != BIT_SAT) begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
               if (shift_edge && !(CPHA && bit_cnt_q == '0)) begin
                  miso_d     = tx_shift_q[BUFFER_SIZE-1];
                  tx_shift_d = tx_shift_q << 1;
               end
            end
         end
         default: state_d = FRM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FRM_IDLE;
         bit_cnt_q     <= '0;
         rx_shift_q    <= '0;
         tx_shift_q    <= '0;
         rx_data_q     <= '0;
         miso_q        <= 1'b0;
         rx_valid_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         tmo_cnt_q     <= TIMEOUT;
         pkg_timeout_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         tx_shift_q    <= tx_shift_d;
         rx_data_q     <= rx_data_d;
         miso_q        <= miso_d;
         rx_valid_q    <= rx_valid_d;
         frame_err_q   <= frame_err_d;
         tmo_cnt_q     <= tmo_cnt_d;
         pkg_timeout_q <= pkg_timeout_d;
      end
   end

   assign SPI_MISO    = miso_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_err   = frame_err_q;
   assign pkg_timeout = pkg_timeout_q;

endmodule
